// File: rtl/vdp_status_ctl_if.sv
// Event ticks, CPU read strobe and status/interrupt outputs of the VDP status block.
// master: timing/sprite engines and CPU port side; slave: vdp_status_ctl.
interface vdp_status_ctl_if;
  logic       frame_tick;
  logic       fifth_tick;
  logic [4:0] fifth_num;
  logic       coinc_tick;
  logic       ie;
  logic       rd;
  logic [7:0] status;
  logic       irq;

  modport master (
    output frame_tick, fifth_tick, fifth_num, coinc_tick, ie, rd,
    input  status, irq
  );

  modport slave (
    input  frame_tick, fifth_tick, fifth_num, coinc_tick, ie, rd,
    output status, irq
  );
endinterface

// File: rtl/vdp_status_ctl.sv
// VDP status register {F, 5S, C, num} with snapshot-on-read and selective clear,
// so that events arriving while the CPU is reading are held for the next read.
module vdp_status_ctl (
  input  logic              clk,
  input  logic              reset_n,
  vdp_status_ctl_if.slave   bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHold  = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  logic [1:0] state_q, state_d;
  logic       f_q, s5_q, c_q;
  logic       f_d, s5_d, c_d;
  logic [4:0] num_q, num_d;
  logic [7:0] snap_q;
  logic       rd_q;
  logic       irq_q;

  logic [7:0] live;
  logic       rise, fall, in_clear;
  logic       f_clr, s5_clr, c_clr;
  logic       fifth_accept;

  assign live     = {f_q, s5_q, c_q, num_q};
  assign rise     = bus.rd & ~rd_q;
  assign fall     = ~bus.rd & rd_q;
  assign in_clear = (state_q == StClear);

  // Only flags that were visible in the snapshot are cleared.
  assign f_clr  = in_clear & snap_q[7];
  assign s5_clr = in_clear & snap_q[6];
  assign c_clr  = in_clear & snap_q[5];

  // Set wins over clear; a 5th-sprite tick colliding with the 5S clear is a fresh first hit.
  assign fifth_accept = bus.fifth_tick & (~s5_q | s5_clr);

  always_comb begin
    f_d   = bus.frame_tick | (f_q & ~f_clr);
    s5_d  = bus.fifth_tick | (s5_q & ~s5_clr);
    c_d   = bus.coinc_tick | (c_q & ~c_clr);
    num_d = fifth_accept ? bus.fifth_num : num_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StHold;
      StHold:  if (fall) state_d = StClear;
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      f_q     <= 1'b0;
      s5_q    <= 1'b0;
      c_q     <= 1'b0;
      num_q   <= 5'd0;
      snap_q  <= 8'h00;
      rd_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      s5_q    <= s5_d;
      c_q     <= c_d;
      num_q   <= num_d;
      rd_q    <= bus.rd;
      irq_q   <= f_d & bus.ie;
      if (state_q == StIdle && rise) snap_q <= live;
    end
  end

  // Snapshot stays on the bus until the clear completes.
  assign bus.status = (state_q == StIdle) ? live : snap_q;
  assign bus.irq    = irq_q;

endmodule

// File: doc/vdp_status_ctl.md
# vdp_status_ctl

Owns the VDP status register (F, 5S, C, 5th-sprite number) and the interrupt line derived from it. It sits between the VDP video timing and sprite engines, which raise single-cycle event ticks, and the CPU-side status port, which reads and clears the flags. It sequences set/snapshot/clear so that no event arriving during a CPU read is ever lost. It drives the CPU INT line.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately, release synchronous to clk
- frame_tick  in  1  one-cycle pulse at start of vertical blank; sets F
- fifth_tick  in  1  one-cycle pulse when a 5th sprite is found on a line
- fifth_num  in  5  sprite number accompanying fifth_tick
- coinc_tick  in  1  one-cycle pulse on sprite pixel coincidence; sets C
- ie  in  1  interrupt enable (VDP register 1 bit 5), level
- rd  in  1  CPU status-port read strobe, synchronous level, high for ≥1 cycle per read
- status  out  8  {F, 5S, C, num[4:0]} presented to CPU data bus
- irq  out  1  active-high interrupt request

## Operation
- Live flag registers: f, s5, c (1 bit each), num (5 bits).
- f set by frame_tick. c set by coinc_tick.
- fifth_tick with s5==0 sets s5 and loads num<=fifth_num. With s5==1, ignored (first 5th sprite per clear wins).
- rd_d is rd delayed one clk. rise = rd & ~rd_d, fall = ~rd & rd_d.
- FSM states:
  - IDLE: status = live {f,s5,c,num}. On rise: snap <= live value, go HOLD.
  - HOLD: status = snap, frozen while rd stays high. On fall: go CLEAR.
  - CLEAR: for one cycle, f &= ~snap[7], s5 &= ~snap[6], c &= ~snap[5]. Then go IDLE.
- In CLEAR, only flags that were 1 in snap are cleared. A flag set after the snapshot survives and is seen on the next read.
- In CLEAR, the num field is not cleared. num reloads only on the next accepted fifth_tick.
- Simultaneous set and clear on the same flag in the same cycle: set wins, flag = 1.
- A set tick in any state updates the live registers. Ticks are never dropped.
- irq_next = f & ie. irq is registered: irq <= f_next & ie, so it follows F with one cycle latency.
- ie deassert drops irq next cycle and leaves f untouched. Re-asserting ie with f=1 raises irq again.
- Reset (async, any state): f=s5=c=0, num=0, snap=0, rd_d=0, state=IDLE, status=0x00, irq=0.
- rd held high through reset release: rd_d=0, so a rise is detected on the first clk after release and the FSM enters HOLD. This is legal.

## Timing
- Event tick at edge N: live flag = 1 after edge N. status reflects it in IDLE after edge N. irq = 1 after edge N (computed from f_next).
- rd rises before edge R: snap is captured at edge R, and status = snap from edge R.
- rd falls before edge F: state = CLEAR after edge F. Flags are cleared at edge F+1. irq drops at edge F+1 if f was cleared.
- Minimum read: rd high for one cycle gives IDLE→HOLD→CLEAR→IDLE in 3 cycles.
- A rise during CLEAR is deferred. It is seen at IDLE only if rd is still high and rd_d is low; otherwise the read is missed. The CPU side guarantees ≥2 cycles of rd low between reads.
- Status data is stable for the entire rd-high window.

## Test plan
- Reset: assert reset_n=0 mid-HOLD with f=1, irq=1 → status=0x00 and irq=0 immediately (before next edge); state IDLE after release.
- Frame/IRQ: ie=1, frame_tick at edge 10 → irq=1 after edge 10. rd high edges 20–22 → status=0x80 during hold. irq=0 after edge 24 (fall at 23, clear at 24).
- Race: rd rises at edge 30 (snap F=0); frame_tick at edge 31; rd falls at 32 → after clear f=1, irq=1, and next read returns 0x80.
- Set/clear collision: f=1 snapped; frame_tick coincides with CLEAR cycle → f stays 1.
- 5th sprite: fifth_tick num=7, then fifth_tick num=12 before read → status=0x47. After read, status=0x07 and the next fifth_tick num=3 gives 0x43.
- IE gating: f=1, ie=0 → irq=0. Set ie=1 → irq=1 one cycle later. Coinc_tick with ie=1 and f=0 → irq stays 0, status bit5=1.
